vball_video_timing: RTL and testbench
=====================================

Name: vball_video_timing

Overview:
- Parametrised successor to the fixed-geometry video timing generator used by the arcade cores.
- Generates H/V counters, blanking, syncs, NMI, a periodic line IRQ and a programmable raster-compare IRQ with acknowledge.
- Geometry comes from parameters; centering offsets are signed and applied only at frame boundaries.
- Sits between the core's clock-enable domain and the MiSTer video output / CPU interrupt inputs.

Parameters:
- HW, 9, horizontal counter width.
- VW, 9, vertical counter width.
- H_LAST, 384, last hcount value; line length is H_LAST+1 clocks.
- H_BLANK_END, 1, hcount at which hb deasserts.
- H_BLANK_START, 241, hcount at which hb asserts.
- H_SYNC_POS, 297, nominal hs start before offset.
- H_SYNC_LEN, 32, hs low width in counts.
- V_LAST, 262, last vcount value.
- V_BLANK_START, 240, first blanked line.
- V_SYNC_POS, 248, nominal vs start line before offset.
- V_SYNC_LEN, 3, vs low width in lines.
- IRQ_SHIFT, 3, periodic IRQ every 2^IRQ_SHIFT lines.
- HOFS_W, 4, h_center width (signed).
- VOFS_W, 3, v_center width (signed).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ce_pix  in  1  pixel clock enable; all state advances only when high
- flip  in  1  screen flip
- h_center  in  HOFS_W  signed horizontal sync offset
- v_center  in  VOFS_W  signed vertical sync offset
- raster_en  in  1  enable raster-compare IRQ
- raster_line  in  VW  line for raster IRQ
- irq_ack  in  1  clears raster IRQ
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- hb  out  1  horizontal blank, active high
- vb  out  1  vertical blank, active high
- hcount  out  HW  raw horizontal count
- vcount  out  VW  raw vertical count
- vcount_disp  out  VW  flip-adjusted line for renderers
- nmi  out  1  one-clock pulse at vblank start
- irq  out  1  one-clock periodic line pulse
- irq_raster  out  1  level raster IRQ, held until acked
- frame_start  out  1  one-clock pulse at hcount=0, vcount=0

Behaviour:
- Reset (async, reset_n low): hcount=0, vcount=0, hs=1, vs=1, hb=1, vb=0, nmi=0, irq=0, irq_raster=0, frame_start=0. Shadow offsets are loaded from the h_center/v_center inputs.
- The release of reset is synchronised internally with a two-flop synchroniser; counting starts on the first ce_pix after sync release.
- With ce_pix low, all registers hold and pulse outputs are 0.
- Counter advance on each ce_pix:
  - hcount increments.
  - At hcount==H_LAST: hcount goes to 0 and vcount increments; at vcount==V_LAST, vcount goes to 0.
- Shadow offsets: h_center and v_center are sampled into shadow registers only on the wrap from vcount==V_LAST to 0. Mid-frame changes take effect at the next frame.
- Sync positions:
  - HS = H_SYNC_POS − sext(h_shadow), computed modulo (H_LAST+1) in HW+1 bits.
  - VS = V_SYNC_POS − sext(v_shadow), computed modulo (V_LAST+1).
- hb: deasserts on the ce_pix where hcount==H_BLANK_END; asserts where hcount==H_BLANK_START. Registered, so it is valid the clock after the compare.
- hs: goes low at hcount==HS and high at hcount==HS+H_SYNC_LEN (mod line length). A window that wraps past H_LAST must still be exactly H_SYNC_LEN counts long.
- vb, vs: update only on line wrap (hcount==H_LAST).
  - vb goes to 1 when the next vcount is V_BLANK_START, and to 0 when the next vcount is 0.
  - vs goes low when the next vcount is VS and high when it is VS+V_SYNC_LEN, wrapping the same way as hs.
- nmi: registered pulse on the ce_pix where vcount==V_BLANK_START and hcount==0.
- irq: registered pulse where vcount[IRQ_SHIFT-1:0] is all ones and hcount==0.
- irq_raster:
  - Sets when raster_en is high and vcount==raster_line and hcount==0.
  - Clears on irq_ack, evaluated every clk independent of ce_pix.
  - If set and ack occur in the same clk, set wins.
  - A raster_line beyond V_LAST never fires.
- vcount_disp = flip ? (V_BLANK_START−1−vcount) : vcount, truncated to VW bits. It is combinational from vcount and flip; outside the active lines the value is don't-care.
- frame_start: registered pulse on the ce_pix where hcount==0 and vcount==0.

Test Plan:
- Defaults, ce_pix=1, offsets 0 -> line length 385 clocks; frame 263 lines. hs low from hcount 297 to 328; vs low on lines 248–250; vb high on lines 240–262.
- h_center=+3 written at line 100 -> hs start unchanged (297) for the rest of the frame; it moves to 294 from the frame after the next wrap.
- h_center=−8 with H_SYNC_POS=370 -> the hs window wraps: low from 378 through 384, then 0 through 24. Total low width is exactly 32.
- raster_line=50, raster_en=1 -> irq_raster rises at vcount 50, hcount 0. irq_ack pulsed at vcount 60 clears it. irq_ack held high together with a set event keeps it at 1.
- ce_pix toggling every other clk -> counts advance at half rate, and nmi/irq/frame_start widths remain one clk.
- reset_n asserted at vcount 120 -> all outputs go to their reset values immediately, without a clk edge. After release, the first frame_start occurs after one full frame.

Source files
------------

// File: rtl/vball_video_timing.sv
`timescale 1ns/1ps
// Parametrised raster timing for the arcade cores: H/V counters, blanking, syncs,
// frame-boundary centering offsets, NMI, periodic line IRQ and raster-compare IRQ.
module vball_video_timing #(
  parameter int HW            = 9,
  parameter int VW            = 9,
  parameter int H_LAST        = 384,
  parameter int H_BLANK_END   = 1,
  parameter int H_BLANK_START = 241,
  parameter int H_SYNC_POS    = 297,
  parameter int H_SYNC_LEN    = 32,
  parameter int V_LAST        = 262,
  parameter int V_BLANK_START = 240,
  parameter int V_SYNC_POS    = 248,
  parameter int V_SYNC_LEN    = 3,
  parameter int IRQ_SHIFT     = 3,
  parameter int HOFS_W        = 4,
  parameter int VOFS_W        = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              flip,
  input  logic [HOFS_W-1:0] h_center,
  input  logic [VOFS_W-1:0] v_center,
  input  logic              raster_en,
  input  logic [VW-1:0]     raster_line,
  input  logic              irq_ack,
  output logic              hs,
  output logic              vs,
  output logic              hb,
  output logic              vb,
  output logic [HW-1:0]     hcount,
  output logic [VW-1:0]     vcount,
  output logic [VW-1:0]     vcount_disp,
  output logic              nmi,
  output logic              irq,
  output logic              irq_raster,
  output logic              frame_start
);

  localparam logic [HW-1:0] H_LAST_C   = HW'(H_LAST);
  localparam logic [HW-1:0] H_BEND_C   = HW'(H_BLANK_END);
  localparam logic [HW-1:0] H_BSTART_C = HW'(H_BLANK_START);
  localparam logic [VW-1:0] V_LAST_C   = VW'(V_LAST);
  localparam logic [VW-1:0] V_BSTART_C = VW'(V_BLANK_START);
  localparam logic [VW-1:0] V_DISP_TOP = VW'(V_BLANK_START - 1);

  localparam logic signed [HW+1:0] H_LEN_S  = (HW+2)'(H_LAST + 1);
  localparam logic signed [HW+1:0] H_POS_S  = (HW+2)'(H_SYNC_POS);
  localparam logic signed [HW+1:0] H_SLEN_S = (HW+2)'(H_SYNC_LEN);
  localparam logic signed [VW+1:0] V_LEN_S  = (VW+2)'(V_LAST + 1);
  localparam logic signed [VW+1:0] V_POS_S  = (VW+2)'(V_SYNC_POS);
  localparam logic signed [VW+1:0] V_SLEN_S = (VW+2)'(V_SYNC_LEN);

  // Fold a value in (-len, 2*len) back into [0, len) for the sync window edges.
  function automatic logic [HW-1:0] h_mod(input logic signed [HW+1:0] v);
    logic signed [HW+1:0] t;
    t = v;
    if (t[HW+1])           t = t + H_LEN_S;
    else if (t >= H_LEN_S) t = t - H_LEN_S;
    return t[HW-1:0];
  endfunction

  function automatic logic [VW-1:0] v_mod(input logic signed [VW+1:0] v);
    logic signed [VW+1:0] t;
    t = v;
    if (t[VW+1])           t = t + V_LEN_S;
    else if (t >= V_LEN_S) t = t - V_LEN_S;
    return t[VW-1:0];
  endfunction

  logic [1:0]               rst_sync_q;
  logic                     run;
  logic [HW-1:0]            hcount_q, hcount_d;
  logic [VW-1:0]            vcount_q, vcount_d;
  logic                     h_at_last, v_at_last, line_start, adv, raster_set;
  logic                     hs_q, vs_q, hb_q, vb_q, started_q;
  logic                     nmi_q, irq_q, irq_raster_q, frame_start_q;
  logic signed [HOFS_W-1:0] h_shad_q;
  logic signed [VOFS_W-1:0] v_shad_q;
  logic signed [HW+1:0]     h_ofs_s;
  logic signed [VW+1:0]     v_ofs_s;
  logic [HW-1:0]            hs_on, hs_off;
  logic [VW-1:0]            vs_on, vs_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run        = rst_sync_q[1];
  assign adv        = run & ce_pix;
  assign line_start = (hcount_q == '0);
  assign raster_set = adv & raster_en & line_start & (vcount_q == raster_line);

  always_comb begin
    h_at_last = (hcount_q == H_LAST_C);
    v_at_last = (vcount_q == V_LAST_C);
    hcount_d  = h_at_last ? '0 : hcount_q + 1'b1;
    vcount_d  = vcount_q;
    if (h_at_last) vcount_d = v_at_last ? '0 : vcount_q + 1'b1;
  end

  always_comb begin
    h_ofs_s = {{(HW+2-HOFS_W){h_shad_q[HOFS_W-1]}}, h_shad_q};
    v_ofs_s = {{(VW+2-VOFS_W){v_shad_q[VOFS_W-1]}}, v_shad_q};
    hs_on   = h_mod(H_POS_S - h_ofs_s);
    hs_off  = h_mod($signed({2'b00, hs_on}) + H_SLEN_S);
    vs_on   = v_mod(V_POS_S - v_ofs_s);
    vs_off  = v_mod($signed({2'b00, vs_on}) + V_SLEN_S);
  end

  // Counters, shadows and level outputs; syncs compare the upcoming count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hb_q      <= 1'b1;
      vb_q      <= 1'b0;
      started_q <= 1'b0;
      h_shad_q  <= '0;
      v_shad_q  <= '0;
    end else if (!run) begin
      h_shad_q <= h_center;
      v_shad_q <= v_center;
    end else if (ce_pix) begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      started_q <= 1'b1;
      if (h_at_last && v_at_last) begin
        h_shad_q <= h_center;
        v_shad_q <= v_center;
      end
      if (hcount_q == H_BEND_C)        hb_q <= 1'b0;
      else if (hcount_q == H_BSTART_C) hb_q <= 1'b1;
      if (hcount_d == hs_on)           hs_q <= 1'b0;
      else if (hcount_d == hs_off)     hs_q <= 1'b1;
      if (h_at_last) begin
        if (vcount_d == V_BSTART_C) vb_q <= 1'b1;
        else if (vcount_d == '0)    vb_q <= 1'b0;
        if (vcount_d == vs_on)       vs_q <= 1'b0;
        else if (vcount_d == vs_off) vs_q <= 1'b1;
      end
    end
  end

  // Pulses are rewritten every clk so they never outlast one clk; the first
  // frame after reset release is not announced as a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_q         <= 1'b0;
      irq_q         <= 1'b0;
      frame_start_q <= 1'b0;
      irq_raster_q  <= 1'b0;
    end else begin
      nmi_q         <= adv & line_start & (vcount_q == V_BSTART_C);
      irq_q         <= adv & line_start & (&vcount_q[IRQ_SHIFT-1:0]);
      frame_start_q <= adv & started_q & line_start & (vcount_q == '0);
      if (raster_set)   irq_raster_q <= 1'b1;
      else if (irq_ack) irq_raster_q <= 1'b0;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign hb          = hb_q;
  assign vb          = vb_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign vcount_disp = flip ? (V_DISP_TOP - vcount_q) : vcount_q;
  assign nmi         = nmi_q;
  assign irq         = irq_q;
  assign irq_raster  = irq_raster_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vball_video_timing.sv
`timescale 1ns/1ps
// Directed bench: a small-geometry instance for frame-level behaviour, plus the
// default geometry and a wrapping-hsync geometry for line-level sync/blank timing.
module tb_vball_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, ce_pix, flip, raster_en, irq_ack;
  logic [3:0] h_center, hc_w;
  logic [2:0] v_center;
  logic [8:0] raster_line;

  logic       s_hs, s_vs, s_hb, s_vb, s_nmi, s_irq, s_irq_raster, s_frame_start;
  logic [8:0] s_hcount, s_vcount, s_vcount_disp;
  logic       d_hs, d_vs, d_hb, d_vb, d_nmi, d_irq, d_irq_raster, d_frame_start;
  logic [8:0] d_hcount, d_vcount, d_vcount_disp;
  logic       w_hs, w_vs, w_hb, w_vb, w_nmi, w_irq, w_irq_raster, w_frame_start;
  logic [8:0] w_hcount, w_vcount, w_vcount_disp;

  // Small geometry: 24 clocks per line, 16 lines per frame.
  vball_video_timing #(
    .H_LAST(23), .H_BLANK_END(1), .H_BLANK_START(17), .H_SYNC_POS(19), .H_SYNC_LEN(4),
    .V_LAST(15), .V_BLANK_START(12), .V_SYNC_POS(13), .V_SYNC_LEN(2), .IRQ_SHIFT(2)
  ) u_s (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .flip(flip), .h_center(h_center),
    .v_center(v_center), .raster_en(raster_en), .raster_line(raster_line), .irq_ack(irq_ack),
    .hs(s_hs), .vs(s_vs), .hb(s_hb), .vb(s_vb), .hcount(s_hcount), .vcount(s_vcount),
    .vcount_disp(s_vcount_disp), .nmi(s_nmi), .irq(s_irq), .irq_raster(s_irq_raster),
    .frame_start(s_frame_start)
  );

  vball_video_timing u_d (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .flip(flip), .h_center(h_center),
    .v_center(v_center), .raster_en(raster_en), .raster_line(raster_line), .irq_ack(irq_ack),
    .hs(d_hs), .vs(d_vs), .hb(d_hb), .vb(d_vb), .hcount(d_hcount), .vcount(d_vcount),
    .vcount_disp(d_vcount_disp), .nmi(d_nmi), .irq(d_irq), .irq_raster(d_irq_raster),
    .frame_start(d_frame_start)
  );

  vball_video_timing #(.H_SYNC_POS(370)) u_w (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .flip(flip), .h_center(hc_w),
    .v_center(v_center), .raster_en(raster_en), .raster_line(raster_line), .irq_ack(irq_ack),
    .hs(w_hs), .vs(w_vs), .hb(w_hb), .vb(w_vb), .hcount(w_hcount), .vcount(w_vcount),
    .vcount_disp(w_vcount_disp), .nmi(w_nmi), .irq(w_irq), .irq_raster(w_irq_raster),
    .frame_start(w_frame_start)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_s(input int v, input int h);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (s_vcount == 9'(v) && s_hcount == 9'(h)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk("wait_pos", 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_cnt, d_first, d_last, d_len, w_cnt, n;
    int nmi_n, irq_n, fs_n, rst_n_seen, p0, p48, p_end;
    logic d_hb2, d_hb241, d_hb242, w377, w378, w1_24, w1_25;
    d_cnt = 0; d_first = -1; d_last = -1; d_len = -1; w_cnt = 0;
    d_hb2 = 1'bx; d_hb241 = 1'bx; d_hb242 = 1'bx;
    w377 = 1'bx; w378 = 1'bx; w1_24 = 1'bx; w1_25 = 1'bx;

    reset_n = 1'b0; ce_pix = 1'b1; flip = 1'b0; raster_en = 1'b0; irq_ack = 1'b0;
    h_center = 4'd0; hc_w = 4'b1000; v_center = 3'd0; raster_line = 9'd0;
    tick(3);
    chk("rst_hcount", s_hcount, 0);
    chk("rst_vcount", s_vcount, 0);
    chk("rst_hs", s_hs, 1);
    chk("rst_vs", s_vs, 1);
    chk("rst_hb", s_hb, 1);
    chk("rst_vb", s_vb, 0);
    chk("rst_nmi", s_nmi, 0);
    chk("rst_irq", s_irq, 0);
    chk("rst_irq_raster", s_irq_raster, 0);
    chk("rst_frame_start", s_frame_start, 0);

    reset_n = 1'b1;
    tick(2);
    chk("sync_hold", s_hcount, 0);
    tick(1);
    chk("first_advance", s_hcount, 1);
    chk("first_fs_suppressed", s_frame_start, 0);

    // Line-level scan of the default and wrapped-sync instances.
    for (int i = 0; i < 414; i++) begin
      tick(1);
      if (d_vcount == 9'd0 && d_hs == 1'b0) begin
        d_cnt++;
        if (d_first < 0) d_first = int'(d_hcount);
        d_last = int'(d_hcount);
      end
      if (d_vcount == 9'd1 && d_len < 0) d_len = i + 1;
      if (d_vcount == 9'd0 && d_hcount == 9'd2)   d_hb2   = d_hb;
      if (d_vcount == 9'd0 && d_hcount == 9'd241) d_hb241 = d_hb;
      if (d_vcount == 9'd0 && d_hcount == 9'd242) d_hb242 = d_hb;
      if (w_hs == 1'b0) w_cnt++;
      if (w_vcount == 9'd0 && w_hcount == 9'd377) w377  = w_hs;
      if (w_vcount == 9'd0 && w_hcount == 9'd378) w378  = w_hs;
      if (w_vcount == 9'd1 && w_hcount == 9'd24)  w1_24 = w_hs;
      if (w_vcount == 9'd1 && w_hcount == 9'd25)  w1_25 = w_hs;
    end
    chk("def_line_len", d_len, 384);
    chk("def_hs_first", d_first, 297);
    chk("def_hs_last", d_last, 328);
    chk("def_hs_width", d_cnt, 32);
    chk("def_hb_at2", d_hb2, 0);
    chk("def_hb_at241", d_hb241, 0);
    chk("def_hb_at242", d_hb242, 1);
    chk("wrap_hs_377", w377, 1);
    chk("wrap_hs_378", w378, 0);
    chk("wrap_hs_1_24", w1_24, 0);
    chk("wrap_hs_1_25", w1_25, 1);
    chk("wrap_hs_width", w_cnt, 32);

    // Flip-adjusted display line.
    wait_s(3, 4);
    chk("vdisp_noflip", s_vcount_disp, 3);
    flip = 1'b1;
    #1;
    chk("vdisp_flip", s_vcount_disp, 8);
    flip = 1'b0;

    // Vertical blank/sync, NMI, periodic IRQ, frame start.
    wait_s(6, 1);  chk("irq_line6", s_irq, 0);
    wait_s(7, 1);  chk("irq_line7", s_irq, 1);
    tick(1);       chk("irq_width", s_irq, 0);
    wait_s(11, 5); chk("vb_line11", s_vb, 0);
    wait_s(12, 0); chk("vb_line12", s_vb, 1);
    chk("nmi_before", s_nmi, 0);
    tick(1);       chk("nmi_pulse", s_nmi, 1);
    tick(1);       chk("nmi_width", s_nmi, 0);
    wait_s(12, 23); chk("vs_line12", s_vs, 1);
    wait_s(13, 0);  chk("vs_line13", s_vs, 0);
    wait_s(14, 23); chk("vs_line14", s_vs, 0);
    wait_s(15, 0);  chk("vs_line15", s_vs, 1);
    wait_s(15, 23); chk("vb_line15", s_vb, 1);
    wait_s(0, 0);   chk("vb_line0", s_vb, 0);
    tick(1);        chk("frame_start", s_frame_start, 1);

    // Centering offset takes effect only from the next frame.
    wait_s(5, 0); h_center = 4'd3;
    wait_s(6, 16); chk("hofs_old_16", s_hs, 1);
    wait_s(6, 19); chk("hofs_old_19", s_hs, 0);
    wait_s(1, 15); chk("hofs_new_15", s_hs, 1);
    wait_s(1, 16); chk("hofs_new_16", s_hs, 0);
    wait_s(1, 20); chk("hofs_new_20", s_hs, 1);
    h_center = 4'd0;

    // Raster compare IRQ with acknowledge.
    raster_line = 9'd5; raster_en = 1'b1;
    wait_s(5, 0); chk("raster_before", s_irq_raster, 0);
    tick(1);      chk("raster_set", s_irq_raster, 1);
    wait_s(6, 0); irq_ack = 1'b1;
    tick(1);      irq_ack = 1'b0;
    chk("raster_acked", s_irq_raster, 0);
    wait_s(4, 10); irq_ack = 1'b1;
    wait_s(5, 1);  chk("raster_set_wins", s_irq_raster, 1);
    tick(1);       chk("raster_ack_after", s_irq_raster, 0);
    irq_ack = 1'b0;
    wait_s(5, 1);  chk("raster_reset", s_irq_raster, 1);
    ce_pix = 1'b0;
    tick(5);
    chk("hold_hcount", s_hcount, 1);
    chk("hold_vcount", s_vcount, 5);
    chk("hold_nmi", s_nmi, 0);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("ack_without_ce", s_irq_raster, 0);
    ce_pix = 1'b1;

    raster_line = 9'd20;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (s_irq_raster) n++;
    end
    chk("raster_out_of_range", n, 0);
    raster_en = 1'b0;

    // Half-rate clock enable: one frame of ce pulses over 768 clocks.
    nmi_n = 0; irq_n = 0; fs_n = 0; p48 = -1;
    p0 = int'(s_vcount) * 24 + int'(s_hcount);
    for (int i = 0; i < 768; i++) begin
      tick(1);
      if (s_nmi) nmi_n++;
      if (s_irq) irq_n++;
      if (s_frame_start) fs_n++;
      if (i == 47) p48 = int'(s_vcount) * 24 + int'(s_hcount);
      ce_pix = ~ce_pix;
    end
    p_end = int'(s_vcount) * 24 + int'(s_hcount);
    chk("half_rate_adv48", p48, (p0 + 24) % 384);
    chk("half_rate_frame", p_end, p0);
    chk("half_rate_nmi", nmi_n, 1);
    chk("half_rate_irq", irq_n, 4);
    chk("half_rate_fs", fs_n, 1);

    // Asynchronous reset mid-frame, then one full frame before frame_start.
    wait_s(13, 20);
    chk("pre_rst_hs", s_hs, 0);
    chk("pre_rst_vs", s_vs, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_hcount", s_hcount, 0);
    chk("arst_vcount", s_vcount, 0);
    chk("arst_hs", s_hs, 1);
    chk("arst_vs", s_vs, 1);
    chk("arst_hb", s_hb, 1);
    chk("arst_vb", s_vb, 0);
    chk("arst_irq_raster", s_irq_raster, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rst_n_seen = -1;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (s_frame_start) begin
        rst_n_seen = i + 1;
        break;
      end
    end
    chk("fs_after_reset", rst_n_seen, 387);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
